// File: rtl/uart_ddr_drain_ctrl_pkg.sv
// Shared types and AXI constants for the UART-to-DDR drain sequencer.
package uart_ddr_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } drain_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Number of valid low-order bytes in a beat (1..4) to the matching strobe.
    function automatic logic [3:0] beat_strb(input logic [2:0] nbytes);
        case (nbytes)
            3'd1:    beat_strb = 4'h1;
            3'd2:    beat_strb = 4'h3;
            3'd3:    beat_strb = 4'h7;
            default: beat_strb = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/uart_ddr_drain_ctrl_if.sv
// FIFO read port plus AXI4 write-master channels of the drain sequencer.
interface uart_ddr_drain_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  fifo_empty;
    logic [7:0]            fifo_rdata;
    logic                  fifo_r_en;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [31:0]           m_axi_wdata;
    logic [3:0]            m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        input  fifo_empty, fifo_rdata, m_axi_awready, m_axi_wready,
               m_axi_bresp, m_axi_bvalid,
        output fifo_r_en, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
               m_axi_wlast, m_axi_wvalid, m_axi_bready
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_axi_awready, m_axi_wready,
               m_axi_bresp, m_axi_bvalid,
        input  fifo_r_en, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
               m_axi_wlast, m_axi_wvalid, m_axi_bready
    );
endinterface

// File: rtl/uart_ddr_drain_ctrl_beat_buf.sv
// One-burst staging buffer: byte-lane writes while filling, beat-indexed reads while draining.
module drain_beat_buf #(
    parameter int BURST_LEN = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_word_i,
    input  logic [1:0]       wr_lane_i,
    input  logic [7:0]       wr_byte_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o
);
    logic [BURST_LEN-1:0][31:0] mem_q;

    // Lanes not written by a short (flushed) burst read back as zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_word_i][8*wr_lane_i +: 8] <= wr_byte_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/uart_ddr_drain_ctrl.sv
// Drains FIFO bytes into a local burst buffer and writes them to a circular DDR region over AXI4.
module uart_ddr_drain_ctrl
    import uart_ddr_pkg::*;
#(
    parameter int                  BURST_LEN    = 4,
    parameter int                  ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                  REGION_BYTES = 4096,
    parameter int                  TIMEOUT      = 1024
) (
    input  logic                   rclk,
    input  logic                   rrst,
    uart_ddr_drain_ctrl_if.master  bus,
    output logic                   busy,
    output logic                   wr_err
);
    localparam int BYTES  = 4 * BURST_LEN;
    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(REGION_BYTES - 1);

    drain_state_e          state_q, state_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [7:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic                  awvalid_q, awvalid_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  wlast_q, wlast_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  wr_err_q, wr_err_d;

    logic                  pop;
    logic                  go_aw;
    logic                  buf_clr;
    logic [IDX_W-1:0]      rd_idx;
    logic [31:0]           rd_data;
    logic [2:0]            last_bytes;

    // Pops are held off during reset so no byte is lost to a dropped burst.
    assign pop = rrst && (state_q == ST_FILL) && !bus.fifo_empty &&
                 (byte_cnt_q < CNT_W'(BYTES));
    assign bus.fifo_r_en = pop;

    // Beat 0 is fetched on AW acceptance, later beats one ahead of the current index.
    assign rd_idx     = (state_q == ST_AW) ? '0 : IDX_W'(beat_q + 8'd1);
    assign last_bytes = (byte_cnt_q[1:0] == 2'b00) ? 3'd4 : {1'b0, byte_cnt_q[1:0]};

    drain_beat_buf #(.BURST_LEN(BURST_LEN), .IDX_W(IDX_W)) u_buf (
        .clk       (rclk),
        .rst_n     (rrst),
        .clr_i     (buf_clr),
        .wr_en_i   (pop),
        .wr_word_i (byte_cnt_q[IDX_W+1:2]),
        .wr_lane_i (byte_cnt_q[1:0]),
        .wr_byte_i (bus.fifo_rdata),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    // State and registered AXI outputs.
    always_ff @(posedge rclk) begin
        if (!rrst) begin
            state_q    <= ST_FILL;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            offset_q   <= '0;
            beat_q     <= '0;
            awaddr_q   <= BASE_ADDR;
            awlen_q    <= '0;
            awvalid_q  <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wlast_q    <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idle_q     <= idle_d;
            offset_q   <= offset_d;
            beat_q     <= beat_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awvalid_q  <= awvalid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wlast_q    <= wlast_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Fill / address / data / response sequencing.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idle_d     = idle_q;
        offset_d   = offset_q;
        beat_d     = beat_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awvalid_d  = awvalid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wlast_d    = wlast_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        wr_err_d   = wr_err_q;
        go_aw      = 1'b0;
        buf_clr    = 1'b0;
        case (state_q)
            ST_FILL: begin
                // A pop wins over a pending flush and restarts the idle count.
                if (pop) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    idle_d     = '0;
                    go_aw      = (byte_cnt_q == CNT_W'(BYTES - 1));
                end else if (byte_cnt_q == '0) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    go_aw  = 1'b1;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                if (go_aw) begin
                    state_d   = ST_AW;
                    awvalid_d = 1'b1;
                    awaddr_d  = BASE_ADDR + offset_q;
                    awlen_d   = 8'(({1'b0, byte_cnt_d} + (CNT_W+1)'(3)) >> 2) - 8'd1;
                end
            end
            ST_AW: begin
                if (bus.m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_W;
                    beat_d    = '0;
                    wvalid_d  = 1'b1;
                    wdata_d   = rd_data;
                    wlast_d   = (awlen_q == 8'd0);
                    wstrb_d   = (awlen_q == 8'd0) ? beat_strb(last_bytes) : 4'hF;
                end
            end
            ST_W: begin
                if (bus.m_axi_wready) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wdata_d = rd_data;
                        wlast_d = ((beat_q + 8'd1) == awlen_q);
                        wstrb_d = ((beat_q + 8'd1) == awlen_q) ? beat_strb(last_bytes) : 4'hF;
                    end
                end
            end
            ST_B: begin
                // Failed bursts are only flagged; the region pointer still advances.
                if (bus.m_axi_bvalid) begin
                    bready_d   = 1'b0;
                    wr_err_d   = wr_err_q | (bus.m_axi_bresp != AXI_RESP_OKAY);
                    offset_d   = (offset_q + (ADDR_WIDTH'({1'b0, awlen_q} + 9'd1) << 2)) & OFF_MASK;
                    byte_cnt_d = '0;
                    beat_d     = '0;
                    idle_d     = '0;
                    buf_clr    = 1'b1;
                    state_d    = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awlen   = awlen_q;
    assign bus.m_axi_awsize  = AXI_SIZE_4B;
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wlast   = wlast_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign busy              = (state_q != ST_FILL) || (byte_cnt_q != '0);
    assign wr_err            = wr_err_q;
endmodule

// File: tb/tb_uart_ddr_drain_ctrl.sv
// Self-checking bench: FIFO and AXI slave models plus a byte-stream scoreboard.
module tb_uart_ddr_drain_ctrl;
    localparam int          BURST_LEN = 4;
    localparam int          AW        = 32;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          REGION    = 4096;
    localparam int          TIMEOUT   = 16;
    localparam int          BYTES     = 4 * BURST_LEN;

    logic rclk = 1'b0;
    logic rrst;
    logic busy, wr_err;

    uart_ddr_drain_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    uart_ddr_drain_ctrl #(
        .BURST_LEN(BURST_LEN), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
        .REGION_BYTES(REGION), .TIMEOUT(TIMEOUT)
    ) dut (
        .rclk(rclk), .rrst(rrst), .bus(bus), .busy(busy), .wr_err(wr_err)
    );

    always #5 rclk = ~rclk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  fifoq[$];
    logic [7:0]  stream[$];
    int          exp_len_q[$];
    int          exp_off, fill_cnt, idle, cur_n, cur_beats, beat_i, consumed;
    int          w_done, b_done, err_idx, aw_wait;
    bit          aw_seen, expect_full, stall_mode, in_burst;
    bit          p_awv, p_wv, p_awhs, p_whs;
    logic [31:0] p_awaddr, p_wdata, last_awaddr;
    logic [7:0]  p_awlen, last_awlen;
    logic [3:0]  p_wstrb;
    logic        p_wlast;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifoq.push_back(b);
        stream.push_back(b);
    endtask

    task automatic drive_inputs();
        bus.fifo_empty = (fifoq.size() == 0);
        bus.fifo_rdata = (fifoq.size() == 0) ? 8'h00 : fifoq[0];
        if (stall_mode && bus.m_axi_awvalid && aw_wait < 5) begin
            bus.m_axi_awready = 1'b0;
            aw_wait++;
        end else begin
            bus.m_axi_awready = 1'b1;
        end
        bus.m_axi_wready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.m_axi_bvalid = (w_done > b_done);
        bus.m_axi_bresp  = (b_done == err_idx) ? 2'b10 : 2'b00;
    endtask

    task automatic tick();
        logic        pop, awhs, whs, bhs;
        int          v, n;
        logic [31:0] exp_d;
        logic [3:0]  exp_s;
        bit          last;
        @(negedge rclk);
        if (expect_full) begin
            chk("full_latency_awvalid", 64'(bus.m_axi_awvalid), 64'd1);
            expect_full = 0;
        end
        if (fill_cnt > 0 && !aw_seen) begin
            if (idle == TIMEOUT - 1) chk("flush_not_early", 64'(bus.m_axi_awvalid), 64'd0);
            if (idle == TIMEOUT)     chk("flush_latency", 64'(bus.m_axi_awvalid), 64'd1);
        end
        if (bus.m_axi_awvalid) aw_seen = 1;
        if (p_awv && !p_awhs) begin
            chk("aw_hold_valid", 64'(bus.m_axi_awvalid), 64'd1);
            chk("aw_hold_addr", 64'(bus.m_axi_awaddr), 64'(p_awaddr));
            chk("aw_hold_len", 64'(bus.m_axi_awlen), 64'(p_awlen));
        end
        if (p_wv && !p_whs) begin
            chk("w_hold_valid", 64'(bus.m_axi_wvalid), 64'd1);
            chk("w_hold_data", 64'(bus.m_axi_wdata), 64'(p_wdata));
            chk("w_hold_strb", 64'(bus.m_axi_wstrb), 64'(p_wstrb));
            chk("w_hold_last", 64'(bus.m_axi_wlast), 64'(p_wlast));
        end
        if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_bready)
            chk("no_pop_outside_fill", 64'(bus.fifo_r_en), 64'd0);
        pop      = bus.fifo_r_en;
        awhs     = bus.m_axi_awvalid && bus.m_axi_awready;
        whs      = bus.m_axi_wvalid && bus.m_axi_wready;
        bhs      = bus.m_axi_bvalid && bus.m_axi_bready;
        p_awv    = bus.m_axi_awvalid;  p_awhs = awhs;
        p_wv     = bus.m_axi_wvalid;   p_whs  = whs;
        p_awaddr = bus.m_axi_awaddr;   p_awlen = bus.m_axi_awlen;
        p_wdata  = bus.m_axi_wdata;    p_wstrb = bus.m_axi_wstrb;
        p_wlast  = bus.m_axi_wlast;
        @(posedge rclk);
        #1;
        if (pop) begin
            if (fifoq.size() > 0) void'(fifoq.pop_front());
            fill_cnt++;
            idle = 0;
            if (fill_cnt == BYTES) expect_full = 1;
        end else if (fill_cnt > 0 && !aw_seen) begin
            idle++;
        end
        if (awhs) begin
            n = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : 0;
            chk("aw_bytes", 64'(fill_cnt), 64'(n));
            chk("awaddr", 64'(p_awaddr), 64'(BASE + 32'(exp_off)));
            chk("awlen", 64'(p_awlen), 64'((n + 3) / 4 - 1));
            last_awaddr = p_awaddr;
            last_awlen  = p_awlen;
            cur_n = n; cur_beats = (n + 3) / 4; beat_i = 0; in_burst = 1; aw_wait = 0;
        end
        if (whs) begin
            last  = (beat_i == cur_beats - 1);
            v     = last ? (cur_n - 4 * beat_i) : 4;
            exp_d = '0;
            for (int l = 0; l < v; l++)
                if (stream.size() > 0) exp_d[8*l +: 8] = stream.pop_front();
            exp_s = 4'((1 << v) - 1);
            chk("wdata", 64'(p_wdata), 64'(exp_d));
            chk("wstrb", 64'(p_wstrb), 64'(exp_s));
            chk("wlast", 64'(p_wlast), 64'(last));
            consumed += v;
            beat_i++;
            if (last) w_done++;
        end
        if (bhs) begin
            b_done++;
            exp_off  = (exp_off + 4 * cur_beats) % REGION;
            fill_cnt = 0; consumed = 0; idle = 0; aw_seen = 0; in_burst = 0;
        end
        drive_inputs();
    endtask

    // Reset the DUT and the scoreboard; any half-drained burst is discarded.
    task automatic do_reset(input int cycles);
        rrst = 1'b0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        @(posedge rclk);
        #1;
        @(negedge rclk);
        chk("rst_fifo_r_en", 64'(bus.fifo_r_en), 64'd0);
        chk("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
        chk("rst_wlast", 64'(bus.m_axi_wlast), 64'd0);
        chk("rst_bready", 64'(bus.m_axi_bready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_awaddr", 64'(bus.m_axi_awaddr), 64'(BASE));
        chk("rst_awlen", 64'(bus.m_axi_awlen), 64'd0);
        chk("rst_wdata", 64'(bus.m_axi_wdata), 64'd0);
        chk("rst_wstrb", 64'(bus.m_axi_wstrb), 64'd0);
        repeat (cycles - 1) @(posedge rclk);
        @(posedge rclk);
        #1;
        for (int i = 0; i < fill_cnt - consumed; i++)
            if (stream.size() > 0) void'(stream.pop_front());
        if (!in_burst && fill_cnt > 0 && exp_len_q.size() > 0) void'(exp_len_q.pop_front());
        exp_off = 0; fill_cnt = 0; idle = 0; consumed = 0; beat_i = 0;
        aw_seen = 0; expect_full = 0; in_burst = 0; aw_wait = 0;
        p_awv = 0; p_wv = 0; p_awhs = 0; p_whs = 0;
        w_done = b_done;
        rrst = 1'b1;
        drive_inputs();
    endtask

    task automatic run_bursts(input int target, input int budget);
        for (int i = 0; i < budget && b_done < target; i++) tick();
        chk("burst_count_in_budget", 64'(b_done), 64'(target));
    endtask

    initial begin
        int b0;
        rrst = 1'b0;
        exp_off = 0; fill_cnt = 0; idle = 0; cur_n = 0; cur_beats = 0; beat_i = 0;
        consumed = 0; w_done = 0; b_done = 0; err_idx = -1; aw_wait = 0;
        aw_seen = 0; expect_full = 0; stall_mode = 0; in_burst = 0;
        p_awv = 0; p_wv = 0; p_awhs = 0; p_whs = 0;
        last_awaddr = '0; last_awlen = '0;

        // Reset with a non-empty FIFO, then a full 0x00..0x0F burst.
        for (int i = 0; i < 16; i++) push(8'(i));
        exp_len_q.push_back(16);
        drive_inputs();
        do_reset(3);
        run_bursts(1, 200);
        chk("t1_awaddr", 64'(last_awaddr), 64'(BASE));
        chk("t1_awlen", 64'(last_awlen), 64'd3);
        chk("t1_wr_err", 64'(wr_err), 64'd0);

        // Six bytes then silence: flushed 2-beat burst, next burst 8 bytes on.
        for (int i = 0; i < 6; i++) push(8'($urandom));
        exp_len_q.push_back(6);
        run_bursts(2, 200);
        chk("t2_awlen", 64'(last_awlen), 64'd1);
        chk("t2_awaddr", 64'(last_awaddr), 64'(BASE + 32'd16));
        for (int i = 0; i < 16; i++) push(8'($urandom));
        exp_len_q.push_back(16);
        run_bursts(3, 200);
        chk("t2_next_awaddr", 64'(last_awaddr), 64'(BASE + 32'd24));

        // Back-pressure on AW and W.
        stall_mode = 1;
        for (int i = 0; i < 32; i++) push(8'($urandom));
        exp_len_q.push_back(16);
        exp_len_q.push_back(16);
        run_bursts(5, 600);
        stall_mode = 0;

        // SLVERR on the second burst of three.
        b0 = b_done;
        err_idx = b0 + 1;
        for (int i = 0; i < 48; i++) push(8'($urandom));
        for (int i = 0; i < 3; i++) exp_len_q.push_back(16);
        run_bursts(b0 + 1, 200);
        chk("t5_err_before", 64'(wr_err), 64'd0);
        run_bursts(b0 + 2, 200);
        chk("t5_err_set", 64'(wr_err), 64'd1);
        run_bursts(b0 + 3, 200);
        chk("t5_err_sticky", 64'(wr_err), 64'd1);

        // Reset while the W channel is mid-burst.
        for (int i = 0; i < 16; i++) push(8'($urandom));
        exp_len_q.push_back(16);
        for (int i = 0; i < 200 && !(in_burst && beat_i == 1); i++) tick();
        chk("t6_reached_beat1", 64'(beat_i), 64'd1);
        do_reset(1);

        // 257 full bursts: the region wraps and the last burst lands at BASE.
        b0 = b_done;
        for (int k = 0; k < 257; k++) begin
            for (int i = 0; i < 16; i++) push(8'($urandom));
            exp_len_q.push_back(16);
        end
        run_bursts(b0 + 1, 200);
        chk("t6_fresh_awaddr", 64'(last_awaddr), 64'(BASE));
        run_bursts(b0 + 256, 20000);
        chk("t4_256th_awaddr", 64'(last_awaddr), 64'(BASE + 32'(REGION - 16)));
        run_bursts(b0 + 257, 200);
        chk("t4_wrap_awaddr", 64'(last_awaddr), 64'(BASE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_ddr_drain_ctrl.md
# uart_ddr_drain_ctrl

Read-side sequencer that drains bytes from the UART-to-DDR async FIFO and writes them to DDR as AXI4 INCR write bursts. It drives the FIFO read enable, packs bytes little-endian into 32-bit beats, buffers one burst locally, then runs the AW/W/B handshakes. It lives entirely in the FIFO read clock domain, between the FIFO read port and the AXI master port facing the DDR controller.

## Interface
- BURST_LEN, 4: beats per full burst (1..16).
- ADDR_WIDTH, 32: AXI address width.
- BASE_ADDR, 0: start of the DDR target region; aligned to REGION_BYTES.
- REGION_BYTES, 4096: size of the circular target region; power of two, multiple of 4*BURST_LEN, ≤4096.
- TIMEOUT, 1024: idle cycles before a partial burst is flushed (≥2).

Ports:
- rclk  in  1  clock; one clock only.
- rrst  in  1  reset; synchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  8  FIFO head byte; valid whenever fifo_empty=0.
- fifo_r_en  out  1  pop request; head byte consumed at that rclk edge.
- m_axi_awaddr  out  ADDR_WIDTH  burst start address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  constant 3'b010.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake.
- m_axi_wdata  out  32  beat data.
- m_axi_wstrb  out  4  byte strobes.
- m_axi_wlast  out  1  final beat.
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake.
- busy  out  1  state ≠ FILL or bytes buffered.
- wr_err  out  1  sticky: set on any bresp ≠ OKAY; cleared only by reset.

## Operation
- States: FILL, AW, W, B.
- FILL: fifo_r_en = !fifo_empty && byte_cnt < 4*BURST_LEN. Byte k of the burst goes to buffer word k/4, lane k%4 (bits 8*(k%4)+:8). byte_cnt increments on each pop.
- FILL→AW when byte_cnt reaches 4*BURST_LEN, or when byte_cnt>0 and idle_cnt reaches TIMEOUT-1 (flush). idle_cnt clears on every pop and while byte_cnt=0.
- On entry to AW: beats = ceil(byte_cnt/4); awlen = beats-1; awaddr = BASE_ADDR + offset. awvalid held with stable fields until awready.
- AW→W on awready. W: present beats in order; wvalid held until wready; wstrb=4'hF except on the last beat of a flush, which is 4'h1/3/7 for 1/2/3 valid bytes. wlast on beat beats-1. W→B on the wready of the wlast beat.
- B: bready=1. On bvalid: record wr_err if bresp≠2'b00; offset += 4*beats, modulo REGION_BYTES; clear byte_cnt, beat index, buffer; →FILL.
- No FIFO pops outside FILL; the FIFO absorbs UART traffic during AW/W/B.
- Error responses do not retry or stall; the burst is dropped and draining continues.

## Timing
- Reset (rrst=0 at rclk edge): state=FILL, offset=0, counters=0, wr_err=0, fifo_r_en=0, awvalid=wvalid=wlast=0, bready=0, busy=0, awaddr=BASE_ADDR, awlen=0, wdata=0, wstrb=0. Reset mid-burst drops buffered data; valids drop on the edge after reset without waiting for ready.
- AXI outputs are registered; fifo_r_en is combinational from state, byte_cnt and fifo_empty.
- Full-burst latency: awvalid rises on the cycle after the final pop.
- One pop per cycle maximum; the 4*BURST_LEN-th pop and the FILL→AW transition occur on the same edge.
- Flush: awvalid rises on the cycle after idle_cnt reaches TIMEOUT-1. A pop in that same cycle takes priority, clears idle_cnt, and prevents the flush.
- Offset wrap: the burst ending at REGION_BYTES leaves offset=0. Bursts never cross 4 KB.
- bvalid arriving in the same cycle as the final wready is not accepted; bready is asserted only in B.

## Structure
- Package uart_ddr_pkg holds: the state enum, AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00, and the beat-strobe function (valid bytes → wstrb).
- One natural sub-module, drain_beat_buf: BURST_LEN×32 buffer with byte-lane write and beat-indexed read. Everything else is in one module.

## Test plan
- Push 16 bytes 0x00..0x0F, BURST_LEN=4, ready always high → awaddr=BASE, awlen=3; wdata 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; wstrb=F on all beats; wlast on beat 3 only.
- Push 6 bytes then idle for TIMEOUT cycles → awlen=1; beat1 wdata[15:0]=0x0504, wstrb=4'h3; next burst address = BASE+8.
- Stall awready 5 cycles and wready randomly → awaddr/wdata stable while valid; no fifo_r_en during AW/W/B; data order intact.
- Write 256 full bursts with REGION_BYTES=4096 → 257th burst awaddr=BASE_ADDR.
- Return bresp=2'b10 on burst 2 → wr_err=1 and stays set; burst 3 proceeds normally.
- Assert rrst in W after beat 1 → next edge: wvalid=0, busy=0, awaddr=BASE_ADDR; next 16 bytes form a fresh burst at BASE.
